hazard_wall_controller: RTL and testbench

//  Parametrised lava/hazard wall for the side-scroller. Wall sits idle until first player input,

---
 rtl/hazard_wall_controller.sv | 154 +++++++++++++++
 tb/tb_hazard_wall_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_wall_controller.sv
// Lava/hazard wall: idles until first player input, arms for START_DELAY game ticks,
// then advances by wall_speed per tick with saturating speed, end-stop parking and pushback.
module hazard_wall_controller #(
  parameter int unsigned X_W         = 10,
  parameter int unsigned SPEED_W     = 4,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned WALL_W      = 10,
  parameter int unsigned START_DELAY = 120,
  parameter int unsigned SPEED_INIT  = 1,
  parameter int unsigned SPEED_MAX   = 8,
  parameter int unsigned PUSHBACK    = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_tick,
  input  logic               any_input_level,
  input  logic               speed_boost_pulse,
  input  logic               pushback_pulse,
  input  logic               freeze,
  input  logic [X_W-1:0]     player_x,
  output logic [X_W-1:0]     wall_x,
  output logic [SPEED_W-1:0] wall_speed,
  output logic [1:0]         wall_state,
  output logic               hit_level,
  output logic               hit_pulse
);

  localparam int unsigned CNT_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int unsigned LIM      = SCREEN_W - WALL_W;
  localparam int unsigned LAST_CNT = (START_DELAY > 0) ? START_DELAY - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMING = 2'd1,
    S_ACTIVE = 2'd2,
    S_PARKED = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   delay_cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [X_W-1:0]     wall_x_next;
  logic [SPEED_W-1:0] speed_next;
  logic               hit_next;
  logic               pulse_next;
  logic               advance;
  logic [X_W:0]       sum;
  logic [X_W:0]       reach;
  logic [X_W-1:0]     pushed_x;
  logic               at_end;

  // Frozen ticks are treated exactly like non-tick cycles.
  assign advance    = game_tick && !freeze;
  assign sum        = {1'b0, wall_x} + (X_W+1)'(wall_speed);
  assign at_end     = (sum >= (X_W+1)'(LIM));
  assign pushed_x   = (wall_x >= X_W'(PUSHBACK)) ? (wall_x - X_W'(PUSHBACK)) : '0;
  assign wall_state = state;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      delay_cnt  <= '0;
      wall_x     <= '0;
      wall_speed <= SPEED_W'(SPEED_INIT);
      hit_level  <= 1'b0;
      hit_pulse  <= 1'b0;
    end else begin
      state      <= state_next;
      delay_cnt  <= cnt_next;
      wall_x     <= wall_x_next;
      wall_speed <= speed_next;
      hit_level  <= hit_next;
      hit_pulse  <= pulse_next;
    end
  end

  // Next-state logic; pushback always returns a moving wall to ACTIVE.
  always_comb begin
    state_next = state;
    if (advance) begin
      case (state)
        S_IDLE: begin
          if (any_input_level) begin
            state_next = (START_DELAY == 0) ? S_ACTIVE : S_ARMING;
          end
        end
        S_ARMING: begin
          if (delay_cnt == CNT_W'(LAST_CNT)) begin
            state_next = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (pushback_pulse) begin
            state_next = S_ACTIVE;
          end else if (at_end) begin
            state_next = S_PARKED;
          end
        end
        S_PARKED: begin
          if (pushback_pulse) begin
            state_next = S_ACTIVE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: position, speed, arming counter and collision for the next cycle.
  always_comb begin
    wall_x_next = wall_x;
    speed_next  = wall_speed;
    cnt_next    = delay_cnt;
    hit_next    = hit_level;
    pulse_next  = 1'b0;
    reach       = '0;
    if (advance) begin
      if (speed_boost_pulse && (wall_speed < SPEED_W'(SPEED_MAX))) begin
        speed_next = wall_speed + SPEED_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (any_input_level) begin
            cnt_next = '0;
          end
        end
        S_ARMING: begin
          cnt_next = (delay_cnt == CNT_W'(LAST_CNT)) ? '0 : (delay_cnt + CNT_W'(1));
        end
        S_ACTIVE: begin
          if (pushback_pulse) begin
            wall_x_next = pushed_x;
          end else if (at_end) begin
            wall_x_next = X_W'(LIM);
          end else begin
            wall_x_next = sum[X_W-1:0];
          end
        end
        S_PARKED: begin
          wall_x_next = pushback_pulse ? pushed_x : X_W'(LIM);
        end
        default: wall_x_next = '0;
      endcase
      // Collision uses the post-update position, widened to avoid overflow.
      reach      = {1'b0, wall_x_next} + (X_W+1)'(WALL_W);
      hit_next   = ((state_next == S_ACTIVE) || (state_next == S_PARKED)) &&
                   (reach >= {1'b0, player_x});
      pulse_next = hit_next && !hit_level;
    end
  end

endmodule

// File: tb/tb_hazard_wall_controller.sv
// Directed bench for hazard_wall_controller with default parameters.
module tb_hazard_wall_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       game_tick = 1'b0;
  logic       any_input_level = 1'b0;
  logic       speed_boost_pulse = 1'b0;
  logic       pushback_pulse = 1'b0;
  logic       freeze = 1'b0;
  logic [9:0] player_x = 10'd100;
  logic [9:0] wall_x;
  logic [3:0] wall_speed;
  logic [1:0] wall_state;
  logic       hit_level;
  logic       hit_pulse;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] IDLE = 2'd0, ARMING = 2'd1, ACTIVE = 2'd2, PARKED = 2'd3;

  hazard_wall_controller dut (
    .clk               (clk),
    .rst               (rst),
    .game_tick         (game_tick),
    .any_input_level   (any_input_level),
    .speed_boost_pulse (speed_boost_pulse),
    .pushback_pulse    (pushback_pulse),
    .freeze            (freeze),
    .player_x          (player_x),
    .wall_x            (wall_x),
    .wall_speed        (wall_speed),
    .wall_state        (wall_state),
    .hit_level         (hit_level),
    .hit_pulse         (hit_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_wall(input string tag, input int x, input int spd, input logic [1:0] st);
    check({tag, ".wall_x"}, 32'(wall_x), 32'(x));
    check({tag, ".speed"}, 32'(wall_speed), 32'(spd));
    check({tag, ".state"}, 32'(wall_state), 32'(st));
  endtask

  // One game tick; returns at the negedge right after the active edge.
  task automatic tick(input logic inp, input logic boost, input logic push);
    @(negedge clk);
    any_input_level   = inp;
    speed_boost_pulse = boost;
    pushback_pulse    = push;
    game_tick         = 1'b1;
    @(negedge clk);
    game_tick         = 1'b0;
    any_input_level   = 1'b0;
    speed_boost_pulse = 1'b0;
    pushback_pulse    = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset and idle with no input.
    do_reset();
    check_wall("reset", 0, 1, IDLE);
    check("reset.hit_level", 32'(hit_level), 0);
    check("reset.hit_pulse", 32'(hit_pulse), 0);
    ticks(10);
    check_wall("idle10", 0, 1, IDLE);
    check("idle10.hit_level", 32'(hit_level), 0);

    // Arming: input on tick T, then 120 ticks held at 0.
    player_x = 10'd1023;
    tick(1'b1, 1'b0, 1'b0);
    check_wall("arm_T", 0, 1, ARMING);
    tick(1'b0, 1'b0, 1'b1);
    check_wall("arm_T1_push_ignored", 0, 1, ARMING);
    ticks(118);
    check_wall("arm_T119", 0, 1, ARMING);
    tick(1'b0, 1'b0, 1'b0);
    check_wall("arm_T120", 0, 1, ACTIVE);
    tick(1'b0, 1'b0, 1'b0);
    check_wall("arm_T121", 1, 1, ACTIVE);

    // Speed boosts; same-tick move uses the old speed.
    ticks(16);
    check_wall("move17", 17, 1, ACTIVE);
    tick(1'b0, 1'b1, 1'b0);
    check_wall("boost18", 18, 2, ACTIVE);
    tick(1'b0, 1'b1, 1'b0);
    check_wall("boost20", 20, 3, ACTIVE);
    tick(1'b0, 1'b1, 1'b0);
    check_wall("boost23", 23, 4, ACTIVE);
    ticks(2);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_wall("reach40", 40, 5, ACTIVE);

    // Pushback and boost together: no advance, speed still increments.
    tick(1'b0, 1'b1, 1'b1);
    check_wall("push_boost40", 0, 6, ACTIVE);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check_wall("sat_reach8", 13, 8, ACTIVE);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    check_wall("sat_hold8", 37, 8, ACTIVE);
    tick(1'b0, 1'b0, 1'b1);
    check_wall("push_clamp0", 0, 8, ACTIVE);
    ticks(8);
    check_wall("move64", 64, 8, ACTIVE);
    tick(1'b0, 1'b0, 1'b1);
    check_wall("push_exact64", 0, 8, ACTIVE);

    // End-stop parking.
    ticks(78);
    check_wall("move624", 624, 8, ACTIVE);
    tick(1'b0, 1'b0, 1'b0);
    check_wall("park_clamp", 630, 8, PARKED);
    ticks(2);
    check_wall("park_hold", 630, 8, PARKED);
    tick(1'b0, 1'b0, 1'b1);
    check_wall("park_push", 566, 8, ACTIVE);
    ticks(7);
    check_wall("move622", 622, 8, ACTIVE);
    tick(1'b0, 1'b0, 1'b0);
    check_wall("park_exact", 630, 8, PARKED);
    check("far_player.hit_level", 32'(hit_level), 0);

    // Mid-run reset restarts everything.
    do_reset();
    check_wall("midreset", 0, 1, IDLE);
    check("midreset.hit_level", 32'(hit_level), 0);

    // No hit while arming even if the player overlaps.
    player_x = 10'd5;
    tick(1'b1, 1'b0, 1'b0);
    ticks(10);
    check_wall("arm_overlap", 0, 1, ARMING);
    check("arm_overlap.hit_level", 32'(hit_level), 0);
    player_x = 10'd50;
    ticks(110);
    check_wall("arm2_done", 0, 1, ACTIVE);
    check("arm2_done.hit_level", 32'(hit_level), 0);

    // Collision at wall_x=40 against player_x=50.
    ticks(39);
    check_wall("pre_hit39", 39, 1, ACTIVE);
    check("pre_hit39.hit_level", 32'(hit_level), 0);
    tick(1'b0, 1'b0, 1'b0);
    check("hit40.wall_x", 32'(wall_x), 40);
    check("hit40.hit_level", 32'(hit_level), 1);
    check("hit40.hit_pulse", 32'(hit_pulse), 1);
    @(negedge clk);
    check("hit40_next.hit_pulse", 32'(hit_pulse), 0);
    check("hit40_next.hit_level", 32'(hit_level), 1);
    tick(1'b0, 1'b0, 1'b0);
    check("hit41.hit_level", 32'(hit_level), 1);
    check("hit41.hit_pulse", 32'(hit_pulse), 0);

    // Frozen ticks discard all inputs.
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1);
    check_wall("frozen", 41, 1, ACTIVE);
    check("frozen.hit_level", 32'(hit_level), 1);
    check("frozen.hit_pulse", 32'(hit_pulse), 0);
    freeze = 1'b0;

    do_reset();
    check_wall("final_reset", 0, 1, IDLE);
    check("final_reset.hit_level", 32'(hit_level), 0);
    check("final_reset.hit_pulse", 32'(hit_pulse), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
